// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner: time-multiplexed driver for a bank of seven-segment digits.
// One digit is lit per slot. Each slot begins with a dead time in which every output is dark.
// The shown value is double-buffered, so it only changes at a frame boundary.
module seven_segment_scanner #(
    parameter int DIGITS         = 4,
    parameter int SLOT_CYCLES    = 50000,
    parameter int BLANK_CYCLES   = 500,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int EN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic [DIGITS-1:0]     blank,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg,
    output logic                  seg_dp,
    output logic [DIGITS-1:0]     digit_en,
    output logic                  frame_done
);

    localparam int              CW         = $clog2(SLOT_CYCLES);
    localparam int              IW         = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CW-1:0]   SLOT_LAST  = CW'(SLOT_CYCLES - 1);
    localparam logic [IW-1:0]   IDX_LAST   = IW'(DIGITS - 1);
    localparam logic [31:0]     BLANK_LIM  = 32'(BLANK_CYCLES);
    localparam logic [6:0]      SEG_INV    = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic            SEG_DP_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic [DIGITS-1:0] EN_INV   = (EN_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : '0;

    // Scan position and the two value buffers.
    logic [CW-1:0]        slot_cnt_q, slot_cnt_d;
    logic [IW-1:0]        idx_q, idx_d;
    logic [4*DIGITS-1:0]  pend_value_q, pend_value_d;
    logic [DIGITS-1:0]    pend_dp_q, pend_dp_d;
    logic [DIGITS-1:0]    pend_blank_q, pend_blank_d;
    logic                 pend_valid_q, pend_valid_d;
    logic [4*DIGITS-1:0]  act_value_q, act_value_d;
    logic [DIGITS-1:0]    act_dp_q, act_dp_d;
    logic [DIGITS-1:0]    act_blank_q, act_blank_d;

    // Registered outputs.
    logic [6:0]           seg_q, seg_d;
    logic                 seg_dp_q, seg_dp_d;
    logic [DIGITS-1:0]    digit_en_q, digit_en_d;
    logic                 frame_done_q, frame_done_d;

    // Display decode intermediates.
    logic                 slot_end, frame_end;
    logic [3:0]           cur_nibble;
    logic                 cur_dp, cur_blank, cur_lz, in_dead, lit, all_zero;
    logic [DIGITS-1:0]    lz_dark, en_act;

    // Hex nibble to active-high segment pattern, bit0 = a.
    function automatic logic [6:0] hex_decode(input logic [3:0] n);
        case (n)
            4'h0: hex_decode = 7'h3F;
            4'h1: hex_decode = 7'h06;
            4'h2: hex_decode = 7'h5B;
            4'h3: hex_decode = 7'h4F;
            4'h4: hex_decode = 7'h66;
            4'h5: hex_decode = 7'h6D;
            4'h6: hex_decode = 7'h7D;
            4'h7: hex_decode = 7'h07;
            4'h8: hex_decode = 7'h7F;
            4'h9: hex_decode = 7'h6F;
            4'hA: hex_decode = 7'h77;
            4'hB: hex_decode = 7'h7C;
            4'hC: hex_decode = 7'h39;
            4'hD: hex_decode = 7'h5E;
            4'hE: hex_decode = 7'h79;
            default: hex_decode = 7'h71;
        endcase
    endfunction

    // Advance the slot counter and digit index, swap buffers at the frame end, and capture loads.
    always_comb begin
        slot_cnt_d   = slot_cnt_q + CW'(1);
        idx_d        = idx_q;
        pend_value_d = pend_value_q;
        pend_dp_d    = pend_dp_q;
        pend_blank_d = pend_blank_q;
        pend_valid_d = pend_valid_q;
        act_value_d  = act_value_q;
        act_dp_d     = act_dp_q;
        act_blank_d  = act_blank_q;

        slot_end  = (slot_cnt_q == SLOT_LAST);
        frame_end = slot_end && (idx_q == IDX_LAST);

        if (slot_end) begin
            slot_cnt_d = '0;
            idx_d      = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
        end

        if (frame_end && pend_valid_q) begin
            act_value_d  = pend_value_q;
            act_dp_d     = pend_dp_q;
            act_blank_d  = pend_blank_q;
            pend_valid_d = 1'b0;
        end

        // A load on the frame-end edge takes effect after the old pending contents move to active.
        if (load) begin
            pend_value_d = value;
            pend_dp_d    = dp;
            pend_blank_d = blank;
            pend_valid_d = 1'b1;
        end
    end

    // Work out what the current digit should show, then apply the output polarity.
    always_comb begin
        all_zero   = 1'b1;
        lz_dark    = '0;
        cur_nibble = 4'h0;
        cur_dp     = 1'b0;
        cur_blank  = 1'b0;
        cur_lz     = 1'b0;
        en_act     = '0;

        for (int i = DIGITS - 1; i >= 0; i--) begin
            all_zero   = all_zero & (act_value_q[4*i +: 4] == 4'h0);
            lz_dark[i] = all_zero & (i != 0);
        end

        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IW'(i)) begin
                cur_nibble = act_value_q[4*i +: 4];
                cur_dp     = act_dp_q[i];
                cur_blank  = act_blank_q[i];
                cur_lz     = lz_dark[i];
            end
        end

        in_dead = (32'(slot_cnt_q) < BLANK_LIM);
        lit     = ~(cur_blank | (lz_en & cur_lz) | in_dead);

        if (lit) begin
            for (int i = 0; i < DIGITS; i++) begin
                en_act[i] = (idx_q == IW'(i));
            end
        end

        seg_d        = (lit ? hex_decode(cur_nibble) : 7'h00) ^ SEG_INV;
        seg_dp_d     = (lit & cur_dp) ^ SEG_DP_INV;
        digit_en_d   = en_act ^ EN_INV;
        frame_done_d = frame_end;
    end

    // State and output registers; reset leaves every output in its unlit/inactive level.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_cnt_q   <= '0;
            idx_q        <= '0;
            pend_value_q <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            pend_valid_q <= 1'b0;
            act_value_q  <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            seg_q        <= SEG_INV;
            seg_dp_q     <= SEG_DP_INV;
            digit_en_q   <= EN_INV;
            frame_done_q <= 1'b0;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            idx_q        <= idx_d;
            pend_value_q <= pend_value_d;
            pend_dp_q    <= pend_dp_d;
            pend_blank_q <= pend_blank_d;
            pend_valid_q <= pend_valid_d;
            act_value_q  <= act_value_d;
            act_dp_q     <= act_dp_d;
            act_blank_q  <= act_blank_d;
            seg_q        <= seg_d;
            seg_dp_q     <= seg_dp_d;
            digit_en_q   <= digit_en_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg        = seg_q;
    assign seg_dp     = seg_dp_q;
    assign digit_en   = digit_en_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner: directed frame-by-frame checks of the scanner.
// An active-low instance and an active-high instance share all of their inputs.
module tb_seven_segment_scanner;

   logic        clk;
   logic        reset;
   logic [15:0] value;
   logic [3:0]  dp;
   logic [3:0]  blank;
   logic        lz_en;
   logic        load;

   logic [6:0]  segLow, segHigh;
   logic        segDpLow, segDpHigh;
   logic [3:0]  enLow, enHigh;
   logic        fdLow, fdHigh;

   int testsRun = 0;
   int testsFailed = 0;

   seven_segment_scanner #(
      .DIGITS(4), .SLOT_CYCLES(4), .BLANK_CYCLES(1),
      .SEG_ACTIVE_LOW(1), .EN_ACTIVE_LOW(1)
   ) dutLow (
      .clk(clk), .reset(reset), .value(value), .dp(dp), .blank(blank),
      .lz_en(lz_en), .load(load),
      .seg(segLow), .seg_dp(segDpLow), .digit_en(enLow), .frame_done(fdLow)
   );

   seven_segment_scanner #(
      .DIGITS(4), .SLOT_CYCLES(4), .BLANK_CYCLES(1),
      .SEG_ACTIVE_LOW(0), .EN_ACTIVE_LOW(0)
   ) dutHigh (
      .clk(clk), .reset(reset), .value(value), .dp(dp), .blank(blank),
      .lz_en(lz_en), .load(load),
      .seg(segHigh), .seg_dp(segDpHigh), .digit_en(enHigh), .frame_done(fdHigh)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Count one comparison and report it if the observed value differs from the expected one.
   task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
      testsRun++;
      if (got !== want) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   // Present a new value/dp/blank and raise the load strobe for one cycle.
   task automatic applyStimulus(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b);
      value = v;
      dp    = d;
      blank = b;
      load  = 1'b1;
   endtask

   // Check the 16 output samples of one frame, starting right after a frame boundary.
   // Sample j covers digit j/4 at slot position j%4. Position 0 is the dead cycle.
   // The expected seg and seg_dp values are active-low; the active-high instance expects their inverse.
   // Loads can be raised after samples la and lb.
   task automatic checkFrame(input string name, input logic [3:0] expLit,
                             input logic [27:0] expSeg, input logic [3:0] expDp,
                             input int la, input logic [15:0] va,
                             input int lb, input logic [15:0] vb,
                             input logic [3:0] ldp, input logic [3:0] lblank);
      logic [3:0] en;
      logic [6:0] sg;
      logic       pt;
      logic       fd;
      for (int j = 0; j < 16; j++) begin
         int d;
         @(negedge clk);
         d = j / 4;
         if ((j % 4) != 0 && expLit[d]) begin
            en = ~(4'b0001 << d);
            sg = expSeg[7*d +: 7];
            pt = expDp[d];
         end else begin
            en = 4'hF;
            sg = 7'h7F;
            pt = 1'b1;
         end
         fd = (j == 15);
         checkOutput($sformatf("%s low s%0d {en,seg,dp,fd}", name, j),
                     {19'd0, enLow, segLow, segDpLow, fdLow}, {19'd0, en, sg, pt, fd});
         checkOutput($sformatf("%s high s%0d {en,seg,dp,fd}", name, j),
                     {19'd0, enHigh, segHigh, segDpHigh, fdHigh}, {19'd0, ~en, ~sg, ~pt, fd});
         if (j == la)      applyStimulus(va, ldp, lblank);
         else if (j == lb) applyStimulus(vb, ldp, lblank);
         else              load = 1'b0;
      end
   endtask

   // Main directed sequence.
   initial begin
      reset = 1'b1;
      value = 16'h0;
      dp    = 4'h0;
      blank = 4'h0;
      lz_en = 1'b0;
      load  = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (6) @(negedge clk);

      // Reset mid-slot: outputs go unlit and inactive at once, and stay that way.
      reset = 1'b1;
      #1;
      checkOutput("reset async low", {19'd0, enLow, segLow, segDpLow, fdLow}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
      checkOutput("reset async high", {19'd0, enHigh, segHigh, segDpHigh, fdHigh}, 32'd0);
      @(negedge clk);
      checkOutput("reset held low", {19'd0, enLow, segLow, segDpLow, fdLow}, {19'd0, 4'hF, 7'h7F, 1'b1, 1'b0});
      checkOutput("reset held high", {19'd0, enHigh, segHigh, segDpHigh, fdHigh}, 32'd0);

      // Release the reset and load 0x1234 on the first edge. The first frame still shows 0000.
      @(negedge clk);
      reset = 1'b0;
      applyStimulus(16'h1234, 4'h0, 4'h0);
      checkFrame("f1 0000", 4'b1111, {7'h40, 7'h40, 7'h40, 7'h40}, 4'b1111,
                 -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);

      // 1234 with suppression on, which has no effect because digit 3 is non-zero; queue 0x0050.
      lz_en = 1'b1;
      checkFrame("f2 1234", 4'b1111, {7'h79, 7'h24, 7'h30, 7'h19}, 4'b1111,
                 3, 16'h0050, -1, 16'h0, 4'h0, 4'h0);

      // 0050: digits 3 and 2 suppressed; queue 0x0000.
      checkFrame("f3 0050", 4'b0011, {7'h7F, 7'h7F, 7'h12, 7'h40}, 4'b1111,
                 5, 16'h0000, -1, 16'h0, 4'h0, 4'h0);

      // 0000: only digit 0 stays lit; queue 0x8008 with blank=0010, dp=0100.
      checkFrame("f4 0000lz", 4'b0001, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1111,
                 1, 16'h8008, -1, 16'h0, 4'b0100, 4'b0010);

      // 8008: digit 1 is blanked; digit 2 is an inner zero, shown with its dp lit.
      // Queue AAAA and then BBBB in the same frame.
      checkFrame("f5 8008", 4'b1101, {7'h00, 7'h40, 7'h7F, 7'h00}, 4'b1011,
                 2, 16'hAAAA, 9, 16'hBBBB, 4'h0, 4'h0);

      // BBBB wins. Queue DDDD mid-frame, then CCCC on the frame-end edge.
      checkFrame("f6 BBBB", 4'b1111, {7'h03, 7'h03, 7'h03, 7'h03}, 4'b1111,
                 4, 16'hDDDD, 14, 16'hCCCC, 4'h0, 4'h0);

      // DDDD moved to active at that edge; CCCC follows one frame later.
      checkFrame("f7 DDDD", 4'b1111, {7'h21, 7'h21, 7'h21, 7'h21}, 4'b1111,
                 -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);
      checkFrame("f8 CCCC", 4'b1111, {7'h46, 7'h46, 7'h46, 7'h46}, 4'b1111,
                 -1, 16'h0, -1, 16'h0, 4'h0, 4'h0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
